// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding,
// status bit layout and the held FIFO entry format.
package uart_pkg;

    localparam logic [1:0] RXC_IDLE = 2'd0;
    localparam logic [1:0] RXC_EVAL = 2'd1;
    localparam logic [1:0] RXC_OUT  = 2'd2;

    localparam int ST_PE  = 0;
    localparam int ST_FE  = 1;
    localparam int ST_BRK = 2;
    localparam int ST_OVR = 3;
    localparam int ST_TO  = 4;
    localparam int ST_W   = 5;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              pe;
        logic              fe;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Character timeout: counts baud ticks while data waits unread, saturates at
// TIMEOUT_TICKS and pulses reach_o on the tick that gets there.
module uart_rx_timeout #(
    parameter int TIMEOUT_TICKS = 640,
    parameter int TO_CNT_W      = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic tick_i,
    output logic reach_o
);

    localparam logic [TO_CNT_W-1:0] LIMIT    = TO_CNT_W'(TIMEOUT_TICKS);
    localparam logic [TO_CNT_W-1:0] LIMIT_M1 = TO_CNT_W'(TIMEOUT_TICKS - 1);

    logic [TO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (tick_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign reach_o = tick_i & ~clr_i & (cnt_q == LIMIT_M1);

endmodule

// File: rtl/uart_rx_ctrl.sv
// RX FIFO sequencing controller: pops entries, filters errored bytes, hands
// clean bytes out over valid/ready and keeps sticky W1C status plus an IRQ.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 640,
    parameter int TO_CNT_W      = 10,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 drop_err_i,
    input  logic                 baud_tick_i,
    input  logic                 rx_not_empty_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 err_parity_i,
    input  logic                 err_frame_i,
    input  logic                 break_bit_i,
    input  logic                 rx_overrun_i,
    output logic                 rx_rd_en_o,
    output logic [7:0]           data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [ST_W-1:0]      status_o,
    input  logic [ST_W-1:0]      status_clr_i,
    input  logic [ST_W-1:0]      irq_en_i,
    output logic                 irq_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]            state_q, state_d;
    rx_entry_t             entry_p0;
    logic [ST_W-1:0]       status_q, status_set;
    logic                  irq_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic                  brk_prev_q;
    logic                  to_reach;
    logic                  held_err;

    // Pop is gated by reset so no strobe leaks out while the FSM is held.
    assign rx_rd_en_o = (state_q == RXC_IDLE) & en_i & rx_not_empty_i & ~rst_i;
    assign held_err   = entry_p0.pe | entry_p0.fe;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RXC_IDLE: if (rx_rd_en_o) state_d = RXC_EVAL;
            RXC_EVAL: state_d = (held_err && drop_err_i) ? RXC_IDLE : RXC_OUT;
            RXC_OUT:  if (data_ready_i) state_d = RXC_IDLE;
            default:  state_d = RXC_IDLE;
        endcase
    end

    uart_rx_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .TO_CNT_W      (TO_CNT_W)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~rx_not_empty_i | rx_rd_en_o),
        .tick_i  (baud_tick_i),
        .reach_o (to_reach)
    );

    always_comb begin
        status_set         = '0;
        status_set[ST_PE]  = (state_q == RXC_EVAL) & entry_p0.pe;
        status_set[ST_FE]  = (state_q == RXC_EVAL) & entry_p0.fe;
        status_set[ST_BRK] = break_bit_i & ~brk_prev_q;
        status_set[ST_OVR] = rx_overrun_i;
        status_set[ST_TO]  = to_reach;
    end

    // Pop / hold stage: entry captured on the pop edge, evaluated next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RXC_IDLE;
            entry_p0   <= '0;
            err_cnt_q  <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
            brk_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            brk_prev_q <= break_bit_i;
            if (rx_rd_en_o) begin
                entry_p0 <= '{data: rx_data_i, pe: err_parity_i, fe: err_frame_i};
            end
            if ((state_q == RXC_EVAL) && held_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
            // Set beats clear when both hit the same bit.
            status_q <= (status_q & ~status_clr_i) | status_set;
            irq_q    <= |(status_q & irq_en_i);
        end
    end

    assign data_o       = entry_p0.data;
    assign data_valid_o = (state_q == RXC_OUT);
    assign status_o     = status_q;
    assign irq_o        = irq_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
